// File: rtl/mul_unit_pkg.sv
// Shared core definitions for the RV32M multiply group:
// ALU_CON encodings and the multiplier state machine.
package mul_unit_pkg;

  localparam int MUL_W = 32;

  localparam logic [3:0] ALU_MUL    = 4'b1011;
  localparam logic [3:0] ALU_MULH   = 4'b1100;
  localparam logic [3:0] ALU_MULHSU = 4'b1101;
  localparam logic [3:0] ALU_MULHU  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_t;

  function automatic logic is_mul_op(
    input logic [3:0] c
  );
    return (c == ALU_MUL) || (c == ALU_MULH) ||
           (c == ALU_MULHSU) || (c == ALU_MULHU);
  endfunction

endpackage

// File: rtl/mul_unit_if.sv
// Execute-stage request/response bundle between
// the controller and the iterative multiplier.
interface mul_if;
  import mul_unit_pkg::*;

  logic             start;
  logic [3:0]       alu_con;
  logic [MUL_W-1:0] op_a;
  logic [MUL_W-1:0] op_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [MUL_W-1:0] result;

  modport master (
    output start, alu_con, op_a, op_b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, alu_con, op_a, op_b, flush,
    output busy, done, result
  );

endinterface

// File: rtl/mul_unit_cond_negate.sv
// Two's-complement negate-if of a W-bit value.
// Used for operand magnitudes and the final sign fix.
module cond_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  assign o_y = i_neg ? (~i_x + 1'b1) : i_x;

endmodule

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Stalls the pipeline via busy; fixed 34-cycle latency.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic rst,
  mul_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  mul_state_t        r_state;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_a;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              r_hi;
  logic              r_busy;
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_valid;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_valid = is_mul_op(bus.alu_con);
    w_a_neg = ((bus.alu_con == ALU_MULH) ||
               (bus.alu_con == ALU_MULHSU)) &&
              bus.op_a[XLEN-1];
    w_b_neg = (bus.alu_con == ALU_MULH) &&
              bus.op_b[XLEN-1];
  end

  cond_negate #(.W(XLEN)) u_neg_a (
    .i_neg (w_a_neg),
    .i_x   (bus.op_a),
    .o_y   (w_mag_a)
  );

  cond_negate #(.W(XLEN)) u_neg_b (
    .i_neg (w_b_neg),
    .i_x   (bus.op_b),
    .o_y   (w_mag_b)
  );

  cond_negate #(.W(2*XLEN)) u_neg_p (
    .i_neg (r_neg),
    .i_x   (r_acc),
    .o_y   (w_prod)
  );

  // r_a carries mag_a << count; r_b[0] is mag_b[count]
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start && w_valid && !bus.flush) begin
            r_state <= CALC;
            r_busy  <= 1'b1;
            r_a     <= {{XLEN{1'b0}}, w_mag_a};
            r_b     <= w_mag_b;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_hi    <= (bus.alu_con != ALU_MUL);
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(XLEN - 1)) r_state <= FIX;
          end
        end
        FIX: begin
          if (bus.flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_result <= r_hi ? w_prod[2*XLEN-1:XLEN]
                             : w_prod[XLEN-1:0];
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_mul_unit.sv
// Randomized and directed checks of mul_unit against
// a cycle-count model built on plain 64-bit arithmetic.
module tb_mul_unit;
  import mul_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_if u_if ();

  mul_unit #(.XLEN(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit op_ok(input logic [3:0] c);
    return (c >= 4'b1011) && (c <= 4'b1110);
  endfunction

  // Sign-extend as the op demands, multiply modulo 2^64
  function automatic logic [31:0] ref_mul(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] xa, xb, p;
    xa = {32'b0, a};
    xb = {32'b0, b};
    if (op == ALU_MULH || op == ALU_MULHSU)
      xa = {{32{a[31]}}, a};
    if (op == ALU_MULH)
      xb = {{32{b[31]}}, b};
    p = xa * xb;
    return (op == ALU_MUL) ? p[31:0] : p[63:32];
  endfunction

  // m_t = cycles since accepted start (0 = idle)
  int          m_t = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      m_done = 1'b0;
      m_res = '0;
    end else if (m_t == 0) begin
      m_done = 1'b0;
      if (u_if.start && op_ok(u_if.alu_con) && !u_if.flush) begin
        m_t = 1;
        m_pend = ref_mul(u_if.alu_con, u_if.op_a, u_if.op_b);
      end
    end else if (u_if.flush || m_t == 34) begin
      m_t = 0;
      m_done = 1'b0;
    end else begin
      m_t++;
      m_done = (m_t == 34);
      if (m_done) m_res = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", {31'b0, u_if.busy}, {31'b0, m_t != 0});
      chk("done", {31'b0, u_if.done}, {31'b0, m_done});
      chk("result", u_if.result, m_res);
    end
  end

  task automatic run(input string nm,
                     input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] want,
                     input int inj);
    int n;
    int bc;
    bit seen;
    logic [31:0] got;
    n = 0; bc = 0; seen = 1'b0; got = '0;
    @(posedge clk); #1;
    u_if.start = 1'b1;
    u_if.alu_con = op;
    u_if.op_a = a;
    u_if.op_b = b;
    while (n < 40 && !seen) begin
      @(posedge clk); #1;
      n++;
      u_if.start = (n == inj);
      u_if.alu_con = (n == inj) ? ALU_MUL : op;
      u_if.op_a = (n == inj) ? 32'd9 : a;
      u_if.op_b = (n == inj) ? 32'd9 : b;
      @(negedge clk);
      if (u_if.busy) bc++;
      if (u_if.done) begin
        seen = 1'b1;
        got = u_if.result;
      end
    end
    u_if.start = 1'b0;
    chk({nm, " latency"}, n, 34);
    chk({nm, " busy cycles"}, bc, 34);
    chk({nm, " value"}, got, want);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] codes [7];
  int nd;

  initial begin
    codes = '{4'b1011, 4'b1100, 4'b1101, 4'b1110,
              4'b0000, 4'b1010, 4'b1111};
    u_if.start = 1'b0;
    u_if.alu_con = '0;
    u_if.op_a = '0;
    u_if.op_b = '0;
    u_if.flush = 1'b0;

    chk("ref mul", ref_mul(ALU_MUL, 7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk("ref mulh min", ref_mul(ALU_MULH, 32'h80000000, 32'h80000000), 32'h40000000);
    chk("ref mulh -1x2", ref_mul(ALU_MULH, 32'hFFFFFFFF, 2), 32'hFFFFFFFF);
    chk("ref mulhsu", ref_mul(ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("ref mulhu", ref_mul(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);

    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, u_if.busy}, 32'd0);
    chk("reset done", {31'b0, u_if.done}, 32'd0);
    chk("reset result", u_if.result, 32'd0);

    run("mul 7x-3", ALU_MUL, 7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);

    // flush at k+10 keeps prior result, no done
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.alu_con = ALU_MUL;
    u_if.op_a = 2; u_if.op_b = 3;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    u_if.flush = 1'b1;
    @(posedge clk); #1;
    u_if.flush = 1'b0;
    @(negedge clk);
    chk("flush busy", {31'b0, u_if.busy}, 32'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (u_if.done) nd++;
    end
    chk("flush no done", nd, 0);
    chk("flush result", u_if.result, 32'hFFFFFFEB);

    // flush together with start
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.flush = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.flush = 1'b0;
    @(negedge clk);
    chk("flush+start busy", {31'b0, u_if.busy}, 32'd0);

    run("mulh min", ALU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run("mulh -1x2", ALU_MULH, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 0);
    run("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run("mulhu", ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run("busy start", ALU_MULHU, 3, 5, 32'd0, 5);

    // reset during CALC
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.alu_con = ALU_MULHU;
    u_if.op_a = 32'hFFFFFFFF; u_if.op_b = 32'hFFFFFFFF;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid rst busy", {31'b0, u_if.busy}, 32'd0);
    chk("mid rst done", {31'b0, u_if.done}, 32'd0);
    chk("mid rst result", u_if.result, 32'd0);

    // illegal alu_con is ignored
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.alu_con = 4'b0000;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    @(negedge clk);
    chk("bad op busy", {31'b0, u_if.busy}, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      u_if.start = ($urandom % 4) == 0;
      u_if.alu_con = codes[$urandom % 7];
      u_if.op_a = pick();
      u_if.op_b = pick();
      u_if.flush = ($urandom % 97) == 0;
    end
    @(posedge clk); #1;
    u_if.start = 1'b0;
    u_if.flush = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
# mul_unit

Multi-cycle iterative multiplier for the RV32M multiply group. It sits in the execute stage beside the ALU and consumes the 4-bit ALU_CON code produced by the controller for R-type instructions with func7 = 0000001: 1011 MUL, 1100 MULH, 1101 MULHSU, 1110 MULHU. It holds the pipeline through `busy` while a radix-2 shift-add multiply runs, then presents the 32-bit result for write-back with a one-cycle `done` pulse.

## Interface
Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request a multiply. Sampled only in IDLE.
- alu_con  in  4  operation code, sampled with `start`.
- op_a  in  32  rs1 value, sampled with `start`.
- op_b  in  32  rs2 value, sampled with `start`.
- flush  in  1  abort the operation in flight (branch or trap kill).
- busy  out  1  high in every state except IDLE. Drives the pipeline stall.
- done  out  1  one-cycle pulse; `result` is valid in that cycle.
- result  out  32  product word. Held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE:**
  - If `start` is high, `alu_con` is one of 1011..1110, and `flush` is low: go to CALC.
  - On that transition, latch `mag_a`, `mag_b`, `neg`, `hi_sel`, clear the 64-bit accumulator, and set count = 0.
  - A start with any other `alu_con` value is ignored.
- **Sign rules:**
  - `sa` = (op is MULH or MULHSU); `sb` = (op is MULH).
  - `a_neg` = sa & op_a[31]; `b_neg` = sb & op_b[31].
  - `mag_x` = x_neg ? −x : x, as a 32-bit unsigned value. The operand 0x80000000 gives magnitude 0x80000000, which is correct.
  - `neg` = a_neg ^ b_neg.
- **CALC (32 cycles, count 0..31):**
  - If mag_b[count] is set, acc += mag_a << count (64-bit, no overflow is possible).
  - count increments each cycle. At count = 31, go to FIX.
- **FIX (1 cycle):**
  - prod = neg ? (~acc + 1) : acc.
  - `result` register loads prod[63:32] if `hi_sel` (MULH/MULHSU/MULHU), else prod[31:0].
  - Go to DONE.
- **DONE (1 cycle):** `done` = 1, then go to IDLE.
- **Flush:**
  - In CALC, FIX, or DONE: next state is IDLE, no `done` pulse, and `result` is left unchanged.
  - A flush in the same cycle as `start` in IDLE wins: the start is not accepted.
- **Start while busy:** ignored. Operands are not re-latched.
- **Reset values:** state = IDLE, busy = 0, done = 0, result = 0, acc = 0, count = 0. A reset mid-operation aborts it with no `done` pulse.

## Timing
- Start accepted in cycle k → CALC in cycles k+1..k+32 → FIX in k+33 → DONE in k+34. Fixed latency of 34 cycles.
- `busy` is high in cycles k+1..k+34 and low in cycle k. The controller keeps the instruction in execute while `start | busy` is high.
- `done` and `result` are registered outputs. No combinational path runs from the inputs to any output.
- A back-to-back start is accepted at the earliest in cycle k+35 (IDLE), so the throughput is one multiply per 35 cycles.
- A flush sampled in cycle j (k+1 ≤ j ≤ k+34) gives IDLE and busy = 0 in cycle j+1.

## Structure
- Shared package (the existing core package):
  - ALU_CON encodings ALU_MUL = 4'b1011, ALU_MULH = 4'b1100, ALU_MULHSU = 4'b1101, ALU_MULHU = 4'b1110.
  - State enum `mul_state_t` {IDLE, CALC, FIX, DONE}.
- One natural sub-module: `cond_negate`, a parameterised-width two's-complement negate-if. It is used twice at width 32 for the operand magnitudes and once at width 64 for the final sign fix.
- No further hierarchy.

## Test plan
- MUL, op_a = 7, op_b = 0xFFFFFFFD (−3) → `done` in cycle k+34 with result = 0xFFFFFFEB; busy high for exactly 34 cycles.
- MULH, 0x80000000 × 0x80000000 → result = 0x40000000. MULH, 0xFFFFFFFF × 0x00000002 → result = 0xFFFFFFFF.
- MULHSU, 0xFFFFFFFF × 0xFFFFFFFF → result = 0xFFFFFFFF. MULHU, same operands → result = 0xFFFFFFFE.
- Start MULHU 3 × 5, then pulse start with MUL 9 × 9 at k+5 → the second start is ignored; done at k+34 with result = 0; next accepted start only from k+35.
- Start MUL 2 × 3, then flush at k+10 → busy = 0 at k+11, no done pulse, result keeps its prior value. Flush together with start in IDLE → busy stays 0.
- Assert rst at k+20 during CALC → the cycle after reset shows busy = 0, done = 0, result = 0. A start with alu_con = 0000 → no busy, no done.
